// File: rtl/multi_op_calc.sv
// -----------------------------------------------------------------------------
// multi_op_calc
//
// Switch/button calculator. Operands A and B (W bits each) are entered C bits
// at a time from the switches. A 3-bit opcode picks one of eight ALU
// operations. The result and its flags are then paged out C bits at a time on
// the LEDs.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_change  level input; a rising edge loads a chunk (LOAD_A/LOAD_B)
//   btn_enter   level input; a rising edge executes (LOAD_*) or pages (SHOW)
//   btn_cancel  level input; a rising edge aborts back to LOAD_A
//   sw          sw[2:0] = opcode, sw[C+2:3] = data chunk
//   ledr        registered data display (switch mirror or result page + index)
//   ledg        registered display: [7:4] one-hot phase, [3:0] {ovf,carry,zero,neg}
// -----------------------------------------------------------------------------
module multi_op_calc #(
    parameter int W = 32,
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_change,
    input  logic         btn_enter,
    input  logic         btn_cancel,
    input  logic [C+2:0] sw,
    output logic [C+2:0] ledr,
    output logic [7:0]   ledg
);

    localparam int N  = W / C;
    localparam int SH = $clog2(W);

    generate
        if ((W % C) != 0 || N < 2 || N > 8) begin : g_bad_params
            $error("multi_op_calc: W must be a multiple of C with 2 <= W/C <= 8");
        end
    endgenerate

    localparam logic [2:0] IDX_LAST = 3'(N - 1);

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_B = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_SHOW   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // ---------------------------------------------------------------- buttons
    // Bit order is {cancel, enter, change}. armed_q is cleared by reset and
    // masks the first sampled cycle. During that cycle prev only captures the
    // button levels, so a button that is still held when reset releases does
    // not produce a pulse.
    logic [2:0] btn_now;
    logic [2:0] btn_prev_q;
    logic       armed_q;
    logic [2:0] pulse;

    assign btn_now = {btn_cancel, btn_enter, btn_change};
    assign pulse   = btn_now & ~btn_prev_q & {3{armed_q}};

    logic pulse_change, pulse_enter, pulse_cancel;
    assign pulse_change = pulse[0];
    assign pulse_enter  = pulse[1];
    assign pulse_cancel = pulse[2];

    // ------------------------------------------------------------- registers
    logic [1:0]   state_q,  state_d;
    logic [2:0]   idx_q,    idx_d;
    logic [W-1:0] a_q,      a_d;
    logic [W-1:0] b_q,      b_d;
    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q,  flags_d;   // {ovf, carry, zero, neg}
    logic [2:0]   op_q,     op_d;
    logic [C+2:0] ledr_q,   ledr_d;
    logic [7:0]   ledg_q,   ledg_d;

    logic [C-1:0] sw_data;
    assign sw_data = sw[C+2:3];

    // ------------------------------------------------------------------- ALU
    logic [W:0]   sum_ext;
    logic [W:0]   diff_ext;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic         alu_ovf;

    always_comb begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        diff_ext  = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[W-1:0];
                alu_carry = sum_ext[W];
                // Operands share a sign and the sum has the other sign.
                alu_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_ext[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[W-1:0];
                alu_carry = diff_ext[W];   // borrow: A < B unsigned
                // Operands differ in sign and the difference loses A's sign.
                alu_ovf   = (a_q[W-1] != b_q[W-1]) && (diff_ext[W-1] != a_q[W-1]);
            end
            OP_OR:  alu_res = a_q | b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: alu_res = a_q << b_q[SH-1:0];
            OP_SHR: alu_res = a_q >> b_q[SH-1:0];
            OP_SLT: alu_res[0] = $signed(a_q) < $signed(b_q);
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        op_d     = op_q;

        if (pulse_cancel) begin
            state_d  = S_LOAD_A;
            idx_d    = 3'd0;
            a_d      = '0;
            b_d      = '0;
            result_d = '0;
            flags_d  = '0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (pulse_enter) begin
                        op_d    = sw[2:0];
                        state_d = S_EXEC;
                    end else if (pulse_change) begin
                        a_d[idx_q*C +: C] = sw_data;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_LOAD_B;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (pulse_enter) begin
                        op_d    = sw[2:0];
                        state_d = S_EXEC;
                    end else if (pulse_change) begin
                        b_d[idx_q*C +: C] = sw_data;
                        // The index saturates on the top chunk, so extra
                        // presses keep overwriting that chunk.
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                S_EXEC: begin
                    result_d = alu_res;
                    flags_d  = {alu_ovf, alu_carry, (alu_res == '0), alu_res[W-1]};
                    state_d  = S_SHOW;
                    idx_d    = 3'd0;
                end
                S_SHOW: begin
                    if (pulse_enter) begin
                        idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- display
    always_comb begin
        ledr_d = ledr_q;
        ledg_d = 8'h00;
        case (state_q)
            S_LOAD_A: begin
                ledr_d = sw;
                ledg_d = 8'h80;
            end
            S_LOAD_B: begin
                ledr_d = sw;
                ledg_d = 8'h40;
            end
            S_EXEC: begin
                ledr_d = ledr_q;
                ledg_d = 8'h20;
            end
            S_SHOW: begin
                ledr_d = {result_q[idx_q*C +: C], idx_q};
                ledg_d = {4'b0001, flags_q};
            end
            default: begin
                ledr_d = ledr_q;
                ledg_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 3'b000;
            armed_q    <= 1'b0;
            state_q    <= S_LOAD_A;
            idx_q      <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            op_q       <= '0;
            ledr_q     <= '0;
            ledg_q     <= '0;
        end else begin
            btn_prev_q <= btn_now;
            armed_q    <= 1'b1;
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            op_q       <= op_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
        end
    end

    assign ledr = ledr_q;
    assign ledg = ledg_q;

endmodule
